// File: rtl/booth_pkg.sv
// Shared Booth radix-4 definitions: operation codes, engine states and a code
// legality helper used by the decode/accumulate datapath.
package booth_pkg;

    localparam logic [2:0] BOOTH_ZERO = 3'b000;
    localparam logic [2:0] BOOTH_P1   = 3'b001;
    localparam logic [2:0] BOOTH_P2   = 3'b011;
    localparam logic [2:0] BOOTH_M1   = 3'b010;
    localparam logic [2:0] BOOTH_M2   = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // 101/110/111 are never produced by a well-behaved encoder.
    function automatic logic booth_code_legal(input logic [2:0] code);
        return code inside {BOOTH_ZERO, BOOTH_P1, BOOTH_P2, BOOTH_M1, BOOTH_M2};
    endfunction

endpackage

// File: rtl/booth_pp_dec.sv
// Booth radix-4 partial-product decoder: code + signed multiplicand to a
// sign-extended 2*WIDTH-bit partial product (0, +M, +2M, -M, -2M).
module booth_pp_dec
    import booth_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [2:0]         code,
    input  logic [WIDTH-1:0]   m,
    output logic [2*WIDTH-1:0] pp
);

    logic [2*WIDTH-1:0] m_ext;

    assign m_ext = {{WIDTH{m[WIDTH-1]}}, m};

    // NOTE: pp gets a value on every path (default arm) so no latch is inferred.
    always_comb begin
        case (code)
            BOOTH_ZERO: pp = '0;
            BOOTH_P1:   pp = m_ext;
            BOOTH_P2:   pp = m_ext << 1;
            BOOTH_M1:   pp = -m_ext;
            BOOTH_M2:   pp = -(m_ext << 1);
            default:    pp = '0;
        endcase
    end

endmodule

// File: rtl/cla.sv
// W-bit carry-lookahead adder built on a Kogge-Stone prefix network.
module cla #(
    parameter int W = 128
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum
);

    localparam int N = W - 1;

    logic [W-1:0] p;
    logic [N-1:0] g;
    logic [N-1:0] carry;

    // Group generate over bits [i:0]; entry i is the carry into bit i+1.
    function automatic logic [N-1:0] ks_prefix(input logic [N-1:0] g_in,
                                               input logic [N-1:0] p_in);
        logic [N-1:0] gg;
        logic [N-1:0] pp;
        gg = g_in;
        pp = p_in;
        for (int d = 1; d < N; d = d * 2) begin
            gg = gg | (pp & (gg << d));
            pp = pp & ((pp << d) | ((N'(1) << d) - N'(1)));
        end
        return gg;
    endfunction

    assign p     = a ^ b;
    assign g     = (a[N-1:0] & b[N-1:0]) | {{(N-1){1'b0}}, p[0] & cin};
    assign carry = ks_prefix(g, p[N-1:0]);
    assign sum   = p ^ {carry, cin};

endmodule

// File: rtl/booth_pp_acc.sv
// Booth radix-4 decode-and-accumulate engine: one encoded group per handshake,
// LSB group first. Define BOOTH_ACC_OPCHK_EN to abort on illegal codes.
module booth_pp_acc
    import booth_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic                 op_valid,
    input  logic [2:0]           b_op,
    input  logic                 op_last,
    output logic                 op_ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic                 err
);

    localparam int NGROUP = WIDTH / 2;
    localparam int PW     = 2 * WIDTH;
    localparam int KW     = $clog2(NGROUP);

    state_t          state;
    state_t          state_nx;
    logic [WIDTH-1:0] m_reg;
    logic [KW-1:0]   k;
    logic [PW-1:0]   pp;
    logic [PW-1:0]   pp_shift;
    logic [PW-1:0]   acc_sum;
    logic            last_grp;
    logic            code_bad;
    logic            accept;
    logic            start_ok;

    booth_pp_dec #(.WIDTH(WIDTH)) u_dec (
        .code (b_op),
        .m    (m_reg),
        .pp   (pp)
    );

    assign pp_shift = pp << {k, 1'b0};

    cla #(.W(PW)) u_add (
        .a   (product),
        .b   (pp_shift),
        .cin (1'b0),
        .sum (acc_sum)
    );

`ifdef BOOTH_ACC_OPCHK_EN
    assign code_bad = !booth_code_legal(b_op);
`else
    assign code_bad = 1'b0;
`endif

    assign last_grp = (k == KW'(NGROUP - 1));
    assign accept   = op_valid && op_ready;
    assign start_ok = start && (state != ACC);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        op_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = ACC;
            end
            ACC: begin
                op_ready = 1'b1;
                busy     = 1'b1;
                if (op_valid && (code_bad || last_grp)) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = start ? ACC : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Sequencing runs purely on the group count; op_last only flags errors.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_reg   <= '0;
            product <= '0;
            k       <= '0;
            err     <= 1'b0;
        end else if (start_ok) begin
            m_reg   <= multiplicand;
            product <= '0;
            k       <= '0;
            err     <= 1'b0;
        end else if (accept) begin
            if (code_bad) begin
                err <= 1'b1;
            end else begin
                product <= acc_sum;
                k       <= k + KW'(1);
                if (op_last != last_grp) err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_booth_pp_acc.sv
// Self-checking bench for booth_pp_acc: table of directed multiplies plus
// hand-written gap/restart, back-to-back start and mid-operation reset sequences.
module tb_booth_pp_acc;

    localparam int W  = 64;
    localparam int NG = W / 2;

    logic           clk;
    logic           reset_n;
    logic           start;
    logic [W-1:0]   multiplicand;
    logic           op_valid;
    logic [2:0]     b_op;
    logic           op_last;
    logic           op_ready;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;
    logic           err;

    int n_total = 0;
    int n_pass  = 0;

    logic [2:0] ops [NG];

    booth_pp_acc #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .multiplicand (multiplicand),
        .op_valid     (op_valid),
        .b_op         (b_op),
        .op_last      (op_last),
        .op_ready     (op_ready),
        .busy         (busy),
        .done         (done),
        .product      (product),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   m;
        logic [2:0]     op0;
        logic [2:0]     op1;
        logic [2:0]     op2;
        logic [2:0]     op_hi;
        int             last_pos;
        int             abort_at;
        logic [2*W-1:0] exp_p;
        logic           exp_err;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic signed [2*W-1:0] pp_model(input logic [W-1:0] m, input logic [2:0] c);
        logic signed [2*W-1:0] mm;
        mm = {{W{m[W-1]}}, m};
        case (c)
            3'b001:  return mm;
            3'b011:  return mm * 2;
            3'b010:  return -mm;
            3'b100:  return -(mm * 2);
            default: return '0;
        endcase
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, " op_ready"}, 128'(op_ready), 128'(0));
        check({tag, " busy"},     128'(busy),     128'(0));
        check({tag, " done"},     128'(done),     128'(0));
        check({tag, " product"},  product,        128'(0));
        check({tag, " err"},      128'(err),      128'(0));
    endtask

    // Issues start (unless already issued), feeds ops[] with optional idle gaps,
    // checks the running product after every cycle and the done pulse/result.
    task automatic run_mult(input logic [W-1:0] m, input int last_pos, input int abort_at,
                            input int max_gap, input bit mid_start, input bit pre_started,
                            input bit chain, input logic [W-1:0] chain_m,
                            input logic [2*W-1:0] exp_p, input logic exp_err, input string tag);
        logic signed [2*W-1:0] model;
        int n_grp;
        int gaps;
        if (!pre_started) begin
            @(negedge clk);
            start        = 1'b1;
            multiplicand = m;
            @(negedge clk);
        end
        start    = 1'b0;
        op_valid = 1'b0;
        check({tag, " busy after start"},  128'(busy),     128'(1));
        check({tag, " ready after start"}, 128'(op_ready), 128'(1));
        check({tag, " cleared product"},   product,        128'(0));
        model = '0;
        n_grp = (abort_at >= 0) ? abort_at + 1 : NG;
        for (int g = 0; g < n_grp; g++) begin
            gaps = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            if (mid_start && g == 3 && gaps == 0) gaps = 1;
            for (int i = 0; i < gaps; i++) begin
                op_valid = 1'b0;
                if (mid_start && g == 3 && i == 0) begin
                    start        = 1'b1;
                    multiplicand = ~m;
                end
                @(negedge clk);
                start = 1'b0;
                check($sformatf("%s hold g%0d", tag, g), product, model);
                check($sformatf("%s busy g%0d", tag, g), 128'(busy), 128'(1));
            end
            op_valid = 1'b1;
            b_op     = ops[g];
            op_last  = (g == last_pos);
            @(negedge clk);
            model = model + (pp_model(m, ops[g]) <<< (2 * g));
            check($sformatf("%s acc g%0d", tag, g), product, model);
        end
        op_valid = 1'b0;
        op_last  = 1'b0;
        b_op     = 3'b000;
        check({tag, " done pulse"},      128'(done),     128'(1));
        check({tag, " ready in done"},   128'(op_ready), 128'(0));
        check({tag, " final product"},   product,        exp_p);
        check({tag, " err"},             128'(err),      128'(exp_err));
        if (chain) begin
            start        = 1'b1;
            multiplicand = chain_m;
            @(negedge clk);
            check({tag, " done one cycle"},  128'(done), 128'(0));
            check({tag, " restart busy"},    128'(busy), 128'(1));
        end else begin
            @(negedge clk);
            check({tag, " done one cycle"},  128'(done), 128'(0));
            check({tag, " idle busy"},       128'(busy), 128'(0));
            check({tag, " product held"},    product,    exp_p);
            check({tag, " err held"},        128'(err),  128'(exp_err));
        end
    endtask

    initial begin
        reset_n      = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        op_valid     = 1'b0;
        b_op         = 3'b000;
        op_last      = 1'b0;

        vecs[0] = '{64'd3, 3'b001, 3'b001, 3'b000, 3'b000, NG-1, -1, 128'd15, 1'b0};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFF9, 3'b010, 3'b000, 3'b000, 3'b000, NG-1, -1, 128'd7, 1'b0};
        vecs[2] = '{64'h8000_0000_0000_0000, 3'b000, 3'b000, 3'b000, 3'b100, NG-1, -1,
                    128'h4000_0000_0000_0000_0000_0000_0000_0000, 1'b0};
        vecs[3] = '{64'd5, 3'b011, 3'b100, 3'b000, 3'b000, NG-1, -1,
                    128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFE2, 1'b0};
        vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 3'b000, 3'b000, 3'b000, 3'b001, NG-1, -1,
                    128'hFFFF_FFFF_FFFF_FFFF_C000_0000_0000_0000, 1'b0};
        vecs[5] = '{64'h7FFF_FFFF_FFFF_FFFF, 3'b000, 3'b000, 3'b000, 3'b011, NG-1, -1,
                    128'h3FFF_FFFF_FFFF_FFFF_8000_0000_0000_0000, 1'b0};
        vecs[6] = '{64'd3, 3'b001, 3'b001, 3'b000, 3'b000, 5, -1, 128'd15, 1'b1};
`ifdef BOOTH_ACC_OPCHK_EN
        vecs[7] = '{64'd3, 3'b001, 3'b001, 3'b111, 3'b000, NG-1, 2, 128'd15, 1'b1};
`else
        vecs[7] = '{64'd3, 3'b001, 3'b001, 3'b111, 3'b000, NG-1, -1, 128'd15, 1'b0};
`endif

        repeat (2) @(negedge clk);
        check_idle_outputs("in reset");
        reset_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("after reset");

        for (int v = 0; v < 8; v++) begin
            for (int g = 0; g < NG; g++) ops[g] = 3'b000;
            ops[0]    = vecs[v].op0;
            ops[1]    = vecs[v].op1;
            ops[2]    = vecs[v].op2;
            ops[NG-1] = vecs[v].op_hi;
            run_mult(vecs[v].m, vecs[v].last_pos, vecs[v].abort_at, 0, 1'b0, 1'b0, 1'b0, '0,
                     vecs[v].exp_p, vecs[v].exp_err, $sformatf("v%0d", v));
        end

        // Idle gaps and an ignored mid-ACC start, then start accepted during DONE.
        for (int g = 0; g < NG; g++) ops[g] = 3'b000;
        ops[0] = 3'b001;
        ops[1] = 3'b001;
        run_mult(64'd3, NG-1, -1, 3, 1'b1, 1'b0, 1'b1, 64'd1, 128'd15, 1'b0, "gaps");
        for (int g = 0; g < NG; g++) ops[g] = 3'b001;
        run_mult(64'd1, NG-1, -1, 0, 1'b0, 1'b1, 1'b0, '0,
                 128'h0000_0000_0000_0000_5555_5555_5555_5555, 1'b0, "chain");

        // Reset in the middle of a multiply aborts with no done.
        @(negedge clk);
        start        = 1'b1;
        multiplicand = 64'd3;
        @(negedge clk);
        start = 1'b0;
        for (int g = 0; g < 10; g++) begin
            op_valid = 1'b1;
            b_op     = 3'b001;
            @(negedge clk);
        end
        check("pre-reset product", product, 128'd1048575);
        op_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        check_idle_outputs("mid reset");
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle_outputs($sformatf("post reset c%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/booth_pp_acc.md
Name: booth_pp_acc

Overview:
- Booth radix-4 decode-and-accumulate engine: the consumer of the Booth encoder's 3-bit operation codes.
- Accepts one encoded group per handshake, LSB group first; forms the partial product (0, ±M, ±2M) of a latched signed multiplicand M.
- Adds each partial product into a 2*WIDTH-bit accumulator at offset 2k.
- Sits between the Booth encoder and the multiplier's result register; returns the signed product plus a done pulse.

Parameters:
- WIDTH, 64, multiplicand/multiplier width in bits (even, >=4).
- NGROUP, WIDTH/2, number of Booth groups per multiply (derived, not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  begin multiply; sampled in IDLE or DONE only.
- multiplicand  input  WIDTH  signed M, latched on accepted start.
- op_valid  input  1  b_op/op_last valid.
- b_op  input  3  Booth code: 000=0, 001=+M, 011=+2M, 010=-M, 100=-2M.
- op_last  input  1  encoder's final-group flag (s_interrupt), qualified by op_valid.
- op_ready  output  1  engine accepts a group this cycle.
- busy  output  1  high in ACC.
- done  output  1  one-cycle pulse: product final.
- product  output  2*WIDTH  signed accumulated result.
- err  output  1  sticky sequencing error flag.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; op_ready=0, busy=0, done=0, err=0, product=0, k=0, M=0.
- States: IDLE, ACC, DONE.
- IDLE:
  - Outputs low except held product/err.
  - On start: latch M, clear product/err/k; go to ACC next cycle.
- ACC:
  - op_ready=1, busy=1.
  - A group is accepted on op_valid&op_ready.
  - Accepted group: pp = sign-extended (0|M|2M|-M|-2M) to 2*WIDTH; product <= product + (pp << 2k) mod 2^(2*WIDTH); k <= k+1.
  - -M and -2M are formed as two's complement of the sign-extended value. -2M of the most negative M wraps correctly modulo 2^(2*WIDTH).
  - When the accepted group has k==NGROUP-1: go to DONE.
  - op_valid low: hold everything.
  - start in ACC is ignored.
- DONE:
  - Lasts one cycle; done=1, op_ready=0; then IDLE.
  - start during DONE is accepted exactly as in IDLE; done still pulses.
- Latency:
  - product is updated the cycle after each accept.
  - Final product is visible with done, on the cycle after the last accept.
  - product holds until the next accepted start.
- op_last check:
  - op_last=1 with k!=NGROUP-1, or op_last=0 with k==NGROUP-1 → err<=1.
  - Sequencing continues by count; err clears only on start or reset.
- Unused codes (101, 110, 111) are treated as 0 (see optional feature).
- Reset mid-operation aborts immediately; no done is generated.

Optional Feature:
- Macro BOOTH_ACC_OPCHK_EN.
- Defined:
  - An accepted illegal code (101/110/111) sets err.
  - The group is not added and k does not advance.
  - FSM goes straight to DONE; done pulses and the partial product is held.
- Undefined: illegal codes act as 000, with no abort and no err from codes.

Decomposition:
- Shared package/include booth_pkg:
  - Code constants BOOTH_ZERO=3'b000, BOOTH_P1=3'b001, BOOTH_P2=3'b011, BOOTH_M1=3'b010, BOOTH_M2=3'b100.
  - State encodings IDLE/ACC/DONE.
- Sub-module booth_pp_dec: combinational code+M → sign-extended 2*WIDTH-bit partial product. Reused by any parallel multiplier.
- Shift and add stay in booth_pp_acc, using the existing cla adder for the accumulate.

Test Plan:
- M=3, ops 001,001 then 30×000, op_last on group 31 → product=15, done one cycle after the 32nd accept, err=0.
- M=-7, ops 010 then 31×000 (multiplier -1) → product=7 (sign correct across 128 bits).
- M=0x8000_0000_0000_0000, ops 31×000 then 100 at k=31 → product=0x4000_0000_0000_0000_0000_0000_0000_0000.
- Random op_valid gaps (0–3 idle cycles) on the first scenario → identical product; no accept while op_valid=0; start pulsed mid-ACC is ignored.
- op_last asserted at k=5 → err=1 and still 32 accepts, done pulses. reset_n pulsed low at k=10 → all outputs 0, state IDLE, no done.
- With BOOTH_ACC_OPCHK_EN: code 111 at k=2 → err=1, done next cycle, product = sum of groups 0–1. Without the macro, the same stimulus yields a normal 32-group result.
